// File: rtl/avmm_pkg.sv
// Shared types and helpers for the wait-stated Avalon-MM memory slave.
package avmm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  localparam logic [1:0] RESP_OKAY       = 2'b00;
  localparam logic [1:0] RESP_SLAVEERROR = 2'b10;

  // One byte lane of a masked write: take the new byte only where enabled.
  function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       be);
    return be ? new_b : old_b;
  endfunction

endpackage

// File: rtl/avmm_wait_ctrl.sv
// Wait-state sequencer: counts read/write wait cycles and emits waitrequest,
// the read-data load strobe and the write commit strobe.
module avmm_wait_ctrl
  import avmm_pkg::*;
#(
  parameter int WAIT_READ  = 4,
  parameter int WAIT_WRITE = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic cmd,
  input  logic is_write,
  output logic waitrequest,
  output logic wr_commit,
  output logic rd_load
);

  localparam int WMAX = (WAIT_READ > WAIT_WRITE) ? WAIT_READ : WAIT_WRITE;
  localparam int CW   = $clog2(WMAX + 1);
  localparam logic [CW-1:0] RD_LAST = CW'(WAIT_READ - 1);
  localparam logic [CW-1:0] WR_LAST = CW'((WAIT_WRITE > 0) ? WAIT_WRITE - 1 : 0);
  localparam bit WR_DIRECT = (WAIT_WRITE == 0);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [CW-1:0] last;
  logic          direct;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // The IDLE cycle of a command is its first wait cycle, so cnt counts
  // waitrequest-high cycles from zero there.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    wr_commit   = 1'b0;
    rd_load     = 1'b0;
    last        = is_write ? WR_LAST : RD_LAST;
    direct      = is_write && WR_DIRECT;
    waitrequest = reset | (cmd & (state != ACK) & ~direct);
    case (state)
      IDLE, WAIT: begin
        if (!cmd) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (direct) begin
          state_nx  = IDLE;
          cnt_nx    = '0;
          wr_commit = ~reset;
        end else if (cnt == last) begin
          state_nx = ACK;
          cnt_nx   = '0;
          rd_load  = ~is_write & ~reset;
        end else begin
          state_nx = WAIT;
          cnt_nx   = cnt + CW'(1);
        end
      end
      ACK: begin
        state_nx  = IDLE;
        cnt_nx    = '0;
        wr_commit = cmd & is_write & ~reset;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

// File: rtl/avmm_slave_mem_wait.sv
// Avalon-MM slave in front of an on-chip word memory with counted wait-states.
// Optional SLAVEERROR response port: define AVMM_SLAVE_RESP_EN.
module avmm_slave_mem_wait
  import avmm_pkg::*;
#(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int DEPTH      = 1024,
  parameter int WAIT_READ  = 4,
  parameter int WAIT_WRITE = 2,
  parameter int INIT_MODE  = 1,
  localparam int N         = DW / 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] address,
  input  logic          chipselect,
  input  logic          read,
  input  logic          write,
  input  logic [DW-1:0] writedata,
  input  logic [N-1:0]  byteenable,
  output logic          waitrequest,
  output logic [DW-1:0] readdata
`ifdef AVMM_SLAVE_RESP_EN
  ,
  output logic [1:0]    response
`endif
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  typedef logic [DEPTH-1:0][DW-1:0] mem_t;

  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) m[i] = (INIT_MODE == 1) ? DW'(i) : '0;
    return m;
  endfunction

  // Power-up content only; reset leaves the array alone.
  mem_t mem = init_mem();

  logic          cmd;
  logic          oor;
  logic [IW-1:0] idx;
  logic          wr_commit;
  logic          rd_load;

  assign cmd = chipselect & (read ^ write);
  assign oor = ({1'b0, address} >= DEPTH_L);
  assign idx = address[IW-1:0];

  avmm_wait_ctrl #(
    .WAIT_READ (WAIT_READ),
    .WAIT_WRITE(WAIT_WRITE)
  ) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .cmd        (cmd),
    .is_write   (write),
    .waitrequest(waitrequest),
    .wr_commit  (wr_commit),
    .rd_load    (rd_load)
  );

  always_ff @(posedge clk) begin
    if (wr_commit && !oor) begin
      for (int i = 0; i < N; i++)
        mem[idx][8*i +: 8] <= byte_merge(mem[idx][8*i +: 8], writedata[8*i +: 8],
                                         byteenable[i]);
    end
  end

  // Out-of-range reads keep their timing but return zero.
  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else if (rd_load) readdata <= oor ? '0 : mem[idx];
  end

`ifdef AVMM_SLAVE_RESP_EN
  logic accept;
  logic illegal;
  assign accept  = cmd & ~waitrequest;
  assign illegal = chipselect & read & write;

  always_comb begin
    response = RESP_OKAY;
    if (!reset && ((accept && oor) || illegal)) response = RESP_SLAVEERROR;
  end
`endif

endmodule

// File: tb/tb_avmm_slave_mem_wait.sv
// Directed bench for avmm_slave_mem_wait: one default instance and one with
// zero write wait-states, sharing the master-side stimulus.
module tb_avmm_slave_mem_wait;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic [31:0] address;
  logic        cs, rd, wr;
  logic [31:0] wdata;
  logic [3:0]  be;

  logic        a_wreq, b_wreq;
  logic [31:0] a_rdata, b_rdata;
  logic        obs_wreq;
  logic [31:0] obs_rdata;
`ifdef AVMM_SLAVE_RESP_EN
  logic [1:0]  a_resp, b_resp;
  logic [1:0]  obs_resp;
  assign obs_resp = sel ? b_resp : a_resp;
`endif

  int          total = 0;
  int          bad   = 0;
  logic [31:0] expq[$];

  always #5 clk = ~clk;

  assign obs_wreq  = sel ? b_wreq : a_wreq;
  assign obs_rdata = sel ? b_rdata : a_rdata;

  avmm_slave_mem_wait u_dut_a (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (cs & ~sel),
    .read       (rd),
    .write      (wr),
    .writedata  (wdata),
    .byteenable (be),
    .waitrequest(a_wreq),
    .readdata   (a_rdata)
`ifdef AVMM_SLAVE_RESP_EN
    ,
    .response   (a_resp)
`endif
  );

  avmm_slave_mem_wait #(.WAIT_WRITE(0)) u_dut_b (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (cs & sel),
    .read       (rd),
    .write      (wr),
    .writedata  (wdata),
    .byteenable (be),
    .waitrequest(b_wreq),
    .readdata   (b_rdata)
`ifdef AVMM_SLAVE_RESP_EN
    ,
    .response   (b_resp)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    cs = 1'b0;
    rd = 1'b0;
    wr = 1'b0;
  endtask

  // Called just after a posedge; returns just after the posedge ending accept.
  task automatic xact(input string tag, input logic is_wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] b, input int exp_wait);
    int          n;
    bit          done;
    logic [31:0] e;
    address = a;
    wdata   = d;
    be      = b;
    cs      = 1'b1;
    rd      = ~is_wr;
    wr      = is_wr;
    n       = 0;
    done    = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (obs_wreq) n++;
      else done = 1'b1;
    end
    if (!done) check({tag, " timeout"}, 32'(obs_wreq), 32'd0);
    check({tag, " wait"}, 32'(n), 32'(exp_wait));
    if (!is_wr) begin
      e = expq.pop_front();
      if (done) check({tag, " data"}, obs_rdata, e);
    end
`ifdef AVMM_SLAVE_RESP_EN
    if (done) check({tag, " resp"}, 32'(obs_resp), (a >= 32'd1024) ? 32'd2 : 32'd0);
`endif
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rd_word(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input int w);
    expq.push_back(d);
    xact(tag, 1'b0, a, '0, 4'hF, w);
  endtask

  task automatic wr_word(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, input int w);
    xact(tag, 1'b1, a, d, b, w);
  endtask

  initial begin
    sel     = 1'b0;
    reset   = 1'b1;
    address = '0;
    wdata   = '0;
    be      = '0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst wreq a", 32'(a_wreq), 32'd1);
    check("rst wreq b", 32'(b_wreq), 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post-rst wreq", 32'(a_wreq), 32'd0);
    check("post-rst rdata", a_rdata, 32'd0);
    @(posedge clk);
    #1;

    rd_word("rd5", 32'd5, 32'h5, 4);
    wr_word("wr10", 32'd10, 32'hA5A5_A5A5, 4'b0101, 2);
    rd_word("rd10", 32'd10, 32'h00A5_00A5, 4);
    rd_word("rd1023", 32'd1023, 32'd1023, 4);
    rd_word("rd1024", 32'd1024, 32'd0, 4);
    wr_word("wr1024", 32'd1024, 32'hDEAD_BEEF, 4'hF, 2);
    rd_word("rd0", 32'd0, 32'd0, 4);

    // Reset lands in the second wait cycle of a write to 7.
    address = 32'd7;
    wdata   = 32'hFFFF_FFFF;
    be      = 4'hF;
    cs      = 1'b1;
    wr      = 1'b1;
    @(negedge clk);
    check("wr7 wait1", 32'(a_wreq), 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("wr7 rst wreq", 32'(a_wreq), 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    idle();
    @(negedge clk);
    check("rdata after rst", a_rdata, 32'd0);
    @(posedge clk);
    #1;
    rd_word("rd7", 32'd7, 32'd7, 4);

    // Illegal read+write: no stall, no memory effect.
    address = 32'd5;
    wdata   = 32'h0;
    be      = 4'hF;
    cs      = 1'b1;
    rd      = 1'b1;
    wr      = 1'b1;
    @(negedge clk);
    check("illegal wreq", 32'(a_wreq), 32'd0);
`ifdef AVMM_SLAVE_RESP_EN
    check("illegal resp", 32'(a_resp), 32'd2);
`endif
    @(posedge clk);
    #1 idle();
    rd_word("rd5 again", 32'd5, 32'd5, 4);

    // Read without chipselect.
    address = 32'd9;
    rd      = 1'b1;
    @(negedge clk);
    check("nocs wreq", 32'(a_wreq), 32'd0);
    check("nocs rdata", a_rdata, 32'd5);
    @(posedge clk);
    @(negedge clk);
    check("nocs rdata hold", a_rdata, 32'd5);
    @(posedge clk);
    #1 idle();

    // Master abandons a read after two wait cycles.
    address = 32'd20;
    cs      = 1'b1;
    rd      = 1'b1;
    @(negedge clk);
    check("drop wreq", 32'(a_wreq), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1 idle();
    repeat (6) @(negedge clk);
    check("drop rdata hold", a_rdata, 32'd5);
    @(posedge clk);
    #1;
    rd_word("rd20", 32'd20, 32'd20, 4);

    // Zero-wait writes back to back on the second instance.
    sel = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      address = 32'(i);
      wdata   = 32'(i) * 32'h1111_1111;
      be      = 4'hF;
      cs      = 1'b1;
      wr      = 1'b1;
      rd      = 1'b0;
      @(negedge clk);
      check($sformatf("b2b wr%0d wreq", i), 32'(b_wreq), 32'd0);
      @(posedge clk);
      #1;
    end
    idle();
    rd_word("b rd1", 32'd1, 32'h1111_1111, 4);
    rd_word("b rd2", 32'd2, 32'h2222_2222, 4);
    rd_word("b rd3", 32'd3, 32'h3333_3333, 4);
    rd_word("b rd4", 32'd4, 32'h4, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
